// File: rtl/ram_master_pkg.sv
// Shared definitions for the ram_master controller: FSM state encoding and
// default geometry of the 4-word x 4-bit bank array.
package ram_master_pkg;

    localparam int AW_DEF = 2;
    localparam int DW_DEF = 4;
    localparam int BANKS  = 2 ** AW_DEF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        VERIFY,
        DONE
    } state_e;

endpackage

// File: rtl/ram_master_if.sv
// Bus bundle between the requester, ram_master and the bank array.
// master: the controller's view; slave: the requester/array side.
interface ram_master_if #(
    parameter int AW = 2,
    parameter int DW = 4
);
    logic              req;
    logic              wr;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ack;
    logic              busy;
    logic [DW-1:0]     rdata;
    logic              err;
    logic [2**AW-1:0]  mem_sel;
    logic              mem_rw;
    logic [DW-1:0]     mem_din;
    logic [DW-1:0]     mem_dout;

    modport master (
        input  req, wr, addr, wdata, mem_dout,
        output ack, busy, rdata, err, mem_sel, mem_rw, mem_din
    );

    modport slave (
        output req, wr, addr, wdata, mem_dout,
        input  ack, busy, rdata, err, mem_sel, mem_rw, mem_din
    );
endinterface

// File: rtl/ram_master_dec_onehot.sv
// AW-to-2**AW one-hot decoder with enable; all outputs low when disabled.
module dec_onehot #(
    parameter int AW = 2
) (
    input  logic              en_i,
    input  logic [AW-1:0]     addr_i,
    output logic [2**AW-1:0]  sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_master.sv
// Single-word read/write sequencer for the ram1x4 bank array.
// Optional read-back verify of writes: define RAM_MASTER_VERIFY_EN.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          clear,
    ram_master_if.master  bus
);

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic            wr_q;
    logic [DW-1:0]   din_q;
    logic [DW-1:0]   rdata_q;
    logic            ack_q;
    logic            busy_q;
    logic            rw_q;
`ifdef RAM_MASTER_VERIFY_EN
    logic            err_q;
`endif

    // Selection is held from SETUP through DONE, so the strobe never overlaps a select change.
    dec_onehot #(.AW(AW)) u_dec (
        .en_i   (state_q != IDLE),
        .addr_i (addr_q),
        .sel_o  (bus.mem_sel)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
`ifdef RAM_MASTER_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q <= SETUP;
                        addr_q  <= bus.addr;
                        wr_q    <= bus.wr;
                        din_q   <= bus.wdata;
                        busy_q  <= 1'b1;
`ifdef RAM_MASTER_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    rw_q    <= wr_q;
                end
                STROBE: begin
                    rw_q <= 1'b0;
                    if (!wr_q) begin
                        rdata_q <= bus.mem_dout;
                    end
`ifdef RAM_MASTER_VERIFY_EN
                    if (wr_q) begin
                        state_q <= VERIFY;
                    end else begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end
`else
                    state_q <= DONE;
                    ack_q   <= 1'b1;
`endif
                end
`ifdef RAM_MASTER_VERIFY_EN
                VERIFY: begin
                    err_q   <= (bus.mem_dout != din_q);
                    state_q <= DONE;
                    ack_q   <= 1'b1;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    din_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.rdata   = rdata_q;
    assign bus.mem_rw  = rw_q;
    assign bus.mem_din = din_q;
`ifdef RAM_MASTER_VERIFY_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: doc/ram_master.md
# ram_master

Initiator-side controller for the 4-word × 4-bit RAM array built from four `ram1x4` banks. It accepts single-word read/write requests on a req/ack handshake and sequences the bank-side signals with stable setup and hold: one-hot bank select, `rw` strobe and write data. Read data comes back from the ORed bank outputs. It sits between the datapath/test sequencer and the RAM array and is the only block that drives the array.

## Interface
Parameters:
- `AW`, 2: address width; bank count is 2**AW.
- `DW`, 4: data width per word; must match the bank width.

Ports:
- `clock`, in, 1: single system clock; rising-edge.
- `clear`, in, 1: reset, asynchronous, active-high.
- `req`, in, 1: request; sampled only in IDLE.
- `wr`, in, 1: 1 = write, 0 = read; qualified by `req`.
- `addr`, in, AW: word address; qualified by `req`.
- `wdata`, in, DW: write data; qualified by `req`.
- `ack`, out, 1: one-cycle completion pulse.
- `busy`, out, 1: high in every state except IDLE.
- `rdata`, out, DW: last read word; valid from the `ack` of a read and held until the next read completes.
- `err`, out, 1: write-verify mismatch flag. Tied 0 unless `RAM_MASTER_VERIFY_EN` is defined.
- `mem_sel`, out, 2**AW: one-hot bank select; drives each bank's `address` input.
- `mem_rw`, out, 1: write strobe to the banks; 1 only in STROBE for writes.
- `mem_din`, out, DW: data to all banks.
- `mem_dout`, in, DW: OR of all bank outputs. Unselected banks output 0.

## Operation
- States: IDLE, SETUP, STROBE, VERIFY (only with the macro), DONE.
- IDLE:
  - On `req`=1 at a rising edge, latch `addr`, `wr` and `wdata` into internal registers and go to SETUP.
  - `req`=0 stays in IDLE.
- SETUP: `mem_sel` = decoded latched address; `mem_din` = latched data; `mem_rw`=0. Always goes to STROBE.
- STROBE:
  - Selection and data held.
  - Write: `mem_rw`=1.
  - Read: `mem_rw`=0, and `rdata` <= `mem_dout` at the exiting edge.
  - Next state is DONE, or VERIFY for a write when the macro is defined.
- VERIFY: `mem_rw`=0, selection held. At the exiting edge, `err` <= (`mem_dout` != latched data). Goes to DONE.
- DONE:
  - `ack`=1 and `mem_rw`=0.
  - `mem_sel` held this cycle, which gives one cycle of address hold after the strobe falls.
  - Goes to IDLE.
- In IDLE: `mem_sel`=0, `mem_rw`=0, `mem_din`=0.
- `req` during `busy` is ignored, not queued. The requester must hold `req` until it sees `ack` or drop it.
- `req` still high in the cycle after `ack` starts a new transaction. Back-to-back throughput is therefore one op per 4 cycles, or 5 cycles for verified writes.
- `err` is cleared when a new operation is accepted and is only updated by verified writes.
- Latched inputs make mid-transaction changes on `addr`, `wdata` and `wr` harmless.
- `mem_rw` comes from a registered state decode and is glitch-free. The bank gating with `clock` makes the write take effect while `mem_rw`=1 and `clock` is high.

## Timing
- Reset values: state IDLE; `ack`, `busy`, `err`, `mem_rw` = 0; `rdata`, `mem_sel`, `mem_din` = 0.
- Reset mid-operation:
  - All outputs drop immediately (asynchronous).
  - An aborted write may leave the target word partially updated. This is accepted, not signalled.
- Latency from the accepting edge E0 to `ack`:
  - `ack` is high in the cycle after E0+2 for reads and unverified writes.
  - `ack` is high in the cycle after E0+3 for verified writes.
- `rdata` changes at the same edge that raises `ack`. `ack` and the new `rdata` are coincident.
- `mem_sel` is stable from SETUP through DONE. `mem_rw` never rises in the same cycle that `mem_sel` changes.

## Configuration
- `RAM_MASTER_VERIFY_EN` defined:
  - Writes pass through VERIFY, a read-back compare.
  - `err` is driven.
  - Write latency is 4 cycles.
- Not defined:
  - VERIFY state and compare logic are absent.
  - `err` is constant 0.
  - Reads and writes both take 3 cycles.

## Structure
- Shared package `ram_master_pkg`: state enum (IDLE, SETUP, STROBE, VERIFY, DONE), `AW`/`DW` defaults, and a bank-count constant.
- One sub-module, `dec_onehot`: AW-to-2**AW one-hot decoder with an enable input. It produces `mem_sel` and is enabled in SETUP, STROBE, VERIFY and DONE.
- The banks themselves are outside this block. The top-level glue ORs the four bank outputs into `mem_dout`.

## Test plan
- Reset, then write addr=2, wdata=4'hA:
  - `mem_sel`=4'b0100 from SETUP through DONE.
  - `mem_rw`=1 for exactly one cycle.
  - `ack` at E0+3.
  - Read addr=2 afterwards: `rdata`=4'hA with `ack`.
- Write 4'h5/4'hC/4'h3/4'hF to addrs 0–3, then read all four back: each `rdata` matches and the other words are undisturbed.
- `req` toggled with a different `addr` while `busy`=1: request ignored, original transaction completes, no extra `ack`.
- `clear` asserted during STROBE of a write: outputs zero immediately, state IDLE, no `ack`. The next transaction proceeds normally.
- `req` held high continuously with alternating write/read: `ack` every 4 cycles (5 with `RAM_MASTER_VERIFY_EN` on writes), `busy` low for exactly one cycle between transactions.
- With `RAM_MASTER_VERIFY_EN`:
  - Force a `mem_dout` bit stuck-at-0 and write 4'hF: `err`=1 at `ack`.
  - Next accepted op clears `err`.
  - With a good array, `err` stays 0.
